// File: rtl/mult_div_unit_if.sv
// Request/write-back bundle between a requester, the multiply/divide unit and the register file.
// The unit takes the slave side; the requester and register file see the master side.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [ADDR_WIDTH-1:0] dest_address;
  logic                  busy;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [WIDTH-1:0]      write_data;
  logic                  div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, dest_address,
    input  busy, write_enable, write_address, write_data, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_address,
    output busy, write_enable, write_address, write_data, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide, one bit per clock, ending in a single-cycle register
// file write. Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mult_div_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mult_div_unit_if.slave         bus_io
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q;
  logic [1:0]            op_q;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [2*WIDTH-1:0]    acc_q;
  logic [2*WIDTH-1:0]    acc_d;
  logic [CntW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic                  busy_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  dbz_q;

  logic [WIDTH:0]        mul_sum;
  logic [WIDTH:0]        div_rem;
  logic [WIDTH:0]        div_diff;
  logic [WIDTH-1:0]      result;

  // Multiply: upper half accumulates, lower half holds the shrinking multiplier.
  // Divide: upper half is the partial remainder, lower half the dividend/quotient.
  // A zero divisor never fails the trial subtract, giving all-ones quotient and remainder = a.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, b_q};
    acc_d    = '0;
    if (op_q[1]) begin
      if (div_diff[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      else                 acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
    result = op_q[0] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          we_q  <= 1'b0;
          dbz_q <= 1'b0;
          if (bus_io.start) begin
            op_q    <= bus_io.op;
            a_q     <= bus_io.operand_a;
            b_q     <= bus_io.operand_b;
            dest_q  <= bus_io.dest_address;
            acc_q   <= {{WIDTH{1'b0}},
                        bus_io.op[1] ? bus_io.operand_a : bus_io.operand_b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            we_q    <= 1'b1;
            waddr_q <= dest_q;
            wdata_q <= result;
            dbz_q   <= op_q[1] && (b_q == '0);
            state_q <= StDone;
          end
        end
        StDone: begin
          we_q    <= 1'b0;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy          = busy_q;
  assign bus_io.write_enable  = we_q;
  assign bus_io.write_address = waddr_q;
  assign bus_io.write_data    = wdata_q;
  assign bus_io.div_by_zero   = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, write latency/width, ignored starts
// and asynchronous reset, all against hand-computed values.
module tb_mult_div_unit;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   writes;
  int   hit1;

  mult_div_unit_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  mult_div_unit #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file view: every cycle with write_enable high is one write.
  always @(negedge clk) begin
    if (bus.write_enable) begin
      writes = writes + 1;
      if (bus.write_address == 5'd1) hit1 = hit1 + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [4:0] dest);
    bus.start        = 1'b1;
    bus.operand_a    = a;
    bus.operand_b    = b;
    bus.op           = op;
    bus.dest_address = dest;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // n0 = cycles already elapsed since the accept edge.
  task automatic wait_write(input string tag, input int n0, input logic [4:0] exp_addr,
                            input logic [31:0] exp_data, input logic exp_dbz);
    int n;
    int w0;
    n  = n0;
    w0 = writes;
    while (!bus.write_enable && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_addr"}, 64'(bus.write_address), 64'(exp_addr));
    check({tag, "_data"}, 64'(bus.write_data), 64'(exp_data));
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_we_width"}, 64'(bus.write_enable), 64'd0);
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, "_one_write"}, 64'(writes - w0), 64'd1);
  endtask

  initial begin
    int w0;
    total            = 0;
    bad              = 0;
    writes           = 0;
    hit1             = 0;
    bus.start        = 1'b0;
    bus.op           = 2'b00;
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    bus.dest_address = '0;
    reset_n          = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_we", 64'(bus.write_enable), 64'd0);
    check("rst_wdata", 64'(bus.write_data), 64'd0);
    check("rst_waddr", 64'(bus.write_address), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    cycles(3);
    reset_n = 1'b1;

    issue(32'd7, 32'd6, 2'b00, 5'd3);
    check("mul_busy", 64'(bus.busy), 64'd1);
    wait_write("mul_lo", 0, 5'd3, 32'd42, 1'b0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5'd5);
    wait_write("mul_hi_ff", 0, 5'd5, 32'hFFFF_FFFE, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd6);
    wait_write("mul_lo_ff", 0, 5'd6, 32'h0000_0001, 1'b0);

    issue(32'd100, 32'd7, 2'b10, 5'd10);
    wait_write("div_q", 0, 5'd10, 32'd14, 1'b0);
    issue(32'd100, 32'd7, 2'b11, 5'd11);
    wait_write("div_r", 0, 5'd11, 32'd2, 1'b0);
    issue(32'd5, 32'd0, 2'b10, 5'd12);
    wait_write("dz_q", 0, 5'd12, 32'hFFFF_FFFF, 1'b1);
    issue(32'd5, 32'd0, 2'b11, 5'd0);
    wait_write("dz_r", 0, 5'd0, 32'd5, 1'b1);

    // A start pulse mid-run must be dropped, not queued.
    w0 = writes;
    issue(32'd3, 32'd4, 2'b00, 5'd9);
    cycles(9);
    issue(32'd8, 32'd8, 2'b00, 5'd1);
    wait_write("busy_start", 10, 5'd9, 32'd12, 1'b0);
    cycles(40);
    check("busy_start_writes", 64'(writes - w0), 64'd1);
    check("busy_start_idle", 64'(bus.busy), 64'd0);
    check("busy_start_no_dest1", 64'(hit1), 64'd0);

    // Reset while running discards the operation.
    w0 = writes;
    issue(32'd9, 32'd9, 2'b00, 5'd7);
    cycles(14);
    check("midrun_busy_pre", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_busy", 64'(bus.busy), 64'd0);
    check("midrun_we", 64'(bus.write_enable), 64'd0);
    check("midrun_wdata", 64'(bus.write_data), 64'd0);
    check("midrun_waddr", 64'(bus.write_address), 64'd0);
    @(negedge clk);
    cycles(5);
    reset_n = 1'b1;
    cycles(40);
    check("midrun_no_write", 64'(writes - w0), 64'd0);
    issue(32'd2, 32'd5, 2'b00, 5'd4);
    wait_write("post_rst", 0, 5'd4, 32'd10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
